// File: rtl/spi_master_if.sv
// Command/status and serial pins of the SPI initiator, grouped as one bundle.
// 'master' is the view of the initiator block itself, 'slave' is the view of
// whoever issues byte commands and sits on the far end of the wire.
interface spi_master_if;
  logic       start;
  logic       keep_cs;
  logic [7:0] write_value;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] read_value;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs;

  modport master (
    input  start, keep_cs, write_value, spi_miso,
    output ready, busy, done, read_value, spi_clk, spi_mosi, spi_cs
  );

  modport slave (
    output start, keep_cs, write_value, spi_miso,
    input  ready, busy, done, read_value, spi_clk, spi_mosi, spi_cs
  );
endinterface

// File: rtl/spi_master.sv
// Byte-oriented SPI initiator. One byte per start; spi_cs can be held low
// across bytes (HOLD) to build multi-byte transactions. All four CPOL/CPHA
// modes and both bit orders, spi_clk half-period = CLK_DIV system cycles.
module spi_master #(
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int LSBFIRST = 0,
  parameter int CLK_DIV  = 2
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic          IDLE_LVL = (CPOL != 0);
  localparam bit            PHA      = (CPHA != 0);
  localparam bit            LSB      = (LSBFIRST != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;

  logic [2:0]    state;
  logic [DW-1:0] div_cnt;   // position inside the current half-period
  logic [3:0]    tgl_cnt;   // 0-based index of the next spi_clk toggle
  logic          tail;      // all 16 toggles issued, waiting out the last half-period
  logic          keep_q;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          sclk_q, mosi_q, cs_q, done_q;
  logic [7:0]    rd_q;

  logic       ready, half_end, leading, sample_now, shift_now, do_tgl;
  logic [7:0] tx_next, rx_next;

  function automatic logic first_bit(input logic [7:0] b);
    return LSB ? b[0] : b[7];
  endfunction

  // Decode of the current toggle: even 0-based index is a leading edge.
  // CPHA=1 keeps bit 0 on the first leading edge; CPHA=0 has no bit to
  // advance to after the final trailing edge, so mosi holds its last value.
  always_comb begin
    ready      = (state == S_IDLE) || (state == S_HOLD);
    half_end   = (div_cnt == DIV_LAST);
    leading    = ~tgl_cnt[0];
    sample_now = PHA ? ~leading : leading;
    shift_now  = PHA ? (leading && (tgl_cnt != 4'd0))
                     : (~leading && (tgl_cnt != 4'd15));
    do_tgl     = half_end && ((state == S_SETUP) || ((state == S_XFER) && !tail));
    tx_next    = LSB ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
    rx_next    = LSB ? {bus.spi_miso, rx_sr[7:1]} : {rx_sr[6:0], bus.spi_miso};
  end

  // Sequencer plus spi_clk/mosi/miso datapath; every pin is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      tgl_cnt <= '0;
      tail    <= 1'b0;
      keep_q  <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sclk_q  <= IDLE_LVL;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      div_cnt <= half_end ? '0 : div_cnt + DW'(1);
      case (state)
        S_IDLE, S_HOLD: begin
          if (bus.start) begin
            state   <= S_SETUP;
            cs_q    <= 1'b0;
            tx_sr   <= bus.write_value;
            mosi_q  <= first_bit(bus.write_value);
            keep_q  <= bus.keep_cs;
            div_cnt <= '0;
            tgl_cnt <= '0;
            tail    <= 1'b0;
          end
        end
        S_SETUP: if (half_end) state <= S_XFER;
        S_XFER: begin
          if (half_end && tail) begin
            done_q <= 1'b1;
            rd_q   <= rx_sr;
            state  <= keep_q ? S_HOLD : S_REL;
            cs_q   <= ~keep_q;
          end
        end
        S_REL:   if (half_end) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (do_tgl) begin
        sclk_q  <= ~sclk_q;
        tgl_cnt <= tgl_cnt + 4'd1;
        if (tgl_cnt == 4'd15) tail <= 1'b1;
        if (sample_now) rx_sr <= rx_next;
        if (shift_now) begin
          tx_sr  <= tx_next;
          mosi_q <= first_bit(tx_next);
        end
      end
    end
  end

  assign bus.ready      = ready;
  assign bus.busy       = ~ready;
  assign bus.done       = done_q;
  assign bus.read_value = rd_q;
  assign bus.spi_clk    = sclk_q;
  assign bus.spi_mosi   = mosi_q;
  assign bus.spi_cs     = cs_q;
endmodule
